// File: rtl/axis_i2c_rx_fifo_pkg.sv
// axis_i2c_pkg -- shared constants and types for the I2C receive FIFO.
//   DATA_WIDTH_DEF : default byte width carried from the I2C master
//   DEPTH_DEF      : default FIFO depth in entries (power of two, >= 4)
//   DROP_CNT_W     : width of the saturating dropped-byte counter
//   head_src_e     : which register currently drives m_axis_tdata
package axis_i2c_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF      = 16;
  localparam int unsigned DROP_CNT_W     = 8;

  // The head byte comes either from the storage array's read register or
  // from a bypass register loaded straight from the incoming byte.
  typedef enum logic {
    HEAD_RAM = 1'b0,
    HEAD_BYP = 1'b1
  } head_src_e;

endpackage

// File: rtl/axis_i2c_rx_fifo_ram.sv
// i2c_rx_fifo_ram -- simple dual-port storage array, no reset.
//   clk_i     : clock
//   i_we      : write enable
//   i_waddr   : write address
//   i_wdata   : write data
//   i_re      : read enable (read register holds when low)
//   i_raddr   : read address
//   o_rdata   : registered read data (one cycle after i_re)
module i2c_rx_fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                     clk_i,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]    o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axis_i2c_rx_fifo.sv
// axis_i2c_rx_fifo -- buffers bytes read by an I2C master and presents them
// on a first-word-fall-through AXI-Stream master port.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   i2c_rdata_i/rvalid_i: incoming byte and its one-cycle strobe (no backpressure)
//   m_axis_t*           : AXI-Stream output (tdata/tvalid/tready)
//   clear_i             : clears overflow_o and drop_cnt_o
//   overflow_o          : sticky, a byte was dropped on a full FIFO
//   drop_cnt_o          : saturating count of dropped bytes
//   level_o             : stored entries, including the one on the output
module axis_i2c_rx_fifo
  import axis_i2c_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [DATA_WIDTH-1:0]      i2c_rdata_i,
  input  logic                       rvalid_i,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  input  logic                       clear_i,
  output logic                       overflow_o,
  output logic [DROP_CNT_W-1:0]      drop_cnt_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic                  r_tvalid;
  head_src_e             r_head_src;
  logic [DATA_WIDTH-1:0] r_byp_data;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic [PW-1:0]         w_level;
  logic [PW-1:0]         w_level_next;
  logic [PW-1:0]         w_rd_next;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_byp_head;
  logic                  w_ram_head;
  logic [DATA_WIDTH-1:0] w_ram_q;

  always_comb begin
    w_level      = r_wr_ptr - r_rd_ptr;
    w_full       = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_empty      = (r_wr_ptr == r_rd_ptr);
    w_pop        = r_tvalid && m_axis_tready;
    w_push       = rvalid_i && !rst_i && (!w_full || w_pop);
    w_drop       = rvalid_i && !rst_i && w_full && !w_pop;
    w_rd_next    = r_rd_ptr + PW'(w_pop);
    w_level_next = w_level + PW'(w_push) - PW'(w_pop);
    // New head is the incoming byte when it lands in an empty FIFO or
    // replaces the last stored byte; it is never in the array yet then.
    w_byp_head   = w_push && (w_empty || (w_pop && (w_level == PW'(1))));
    // Otherwise a pop with two or more entries fetches the next stored
    // byte; that slot is never the one being written this cycle.
    w_ram_head   = w_pop && (w_level > PW'(1));
  end

  i2c_rx_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk_i  (clk_i),
    .i_we   (w_push),
    .i_waddr(r_wr_ptr[AW-1:0]),
    .i_wdata(i2c_rdata_i),
    .i_re   (w_ram_head),
    .i_raddr(w_rd_next[AW-1:0]),
    .o_rdata(w_ram_q)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_tvalid   <= 1'b0;
      r_head_src <= HEAD_BYP;
      r_byp_data <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_push);
      r_rd_ptr <= w_rd_next;
      r_tvalid <= (w_level_next != '0);

      if (w_byp_head) begin
        r_byp_data <= i2c_rdata_i;
        r_head_src <= HEAD_BYP;
      end else if (w_ram_head) begin
        r_head_src <= HEAD_RAM;
      end

      // Clear wins for the counter, but a coincident drop still flags.
      if (clear_i) begin
        r_overflow <= w_drop;
        r_drop_cnt <= '0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + 1'b1;
        end
      end
    end
  end

  // Both sources are registers that only change when the head advances,
  // so tdata stays stable under backpressure.
  assign m_axis_tdata  = (r_head_src == HEAD_BYP) ? r_byp_data : w_ram_q;
  assign m_axis_tvalid = r_tvalid;
  assign overflow_o    = r_overflow;
  assign drop_cnt_o    = r_drop_cnt;
  assign level_o       = w_level;

endmodule
